// File: rtl/ws2812b_rx.sv
// WS2812B single-wire receiver: decodes 24-bit GRB words onto a ready/valid output.
// Define WS2812B_RX_FORWARD_EN to forward the line once each frame's first word is captured.
module ws2812b_rx #(
  parameter int unsigned CYCLES_HMIN   = 3,
  parameter int unsigned CYCLES_THRESH = 12,
  parameter int unsigned CYCLES_HMAX   = 30,
  parameter int unsigned CYCLES_RESET  = 1000
) (
  input  logic        clk20,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] data_out,
  output logic        valid,
  input  logic        ready,
  output logic        latch,
  output logic        overrun,
  output logic        frame_err,
  output logic        dout
);
  localparam logic [15:0] HMIN_C   = 16'(CYCLES_HMIN);
  localparam logic [15:0] THRESH_C = 16'(CYCLES_THRESH);
  localparam logic [15:0] HMAX_C   = 16'(CYCLES_HMAX);
  localparam logic [15:0] RESET_C  = 16'(CYCLES_RESET);

  typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

  state_t      state_q;
  logic        sync1_q;
  logic        line_q;
  logic [15:0] hi_cnt_q;
  logic [15:0] lo_cnt_q;
  logic [23:0] sr_q;
  logic [4:0]  nbits_q;
  logic        armed_q;

  logic [15:0] hi_inc;
  logic [15:0] lo_inc;
  logic [23:0] word_nx;
  logic        bit_ok;
  logic        word_done;
  logic        too_long;
  logic        gap_hit;

  always_comb begin
    hi_inc    = (hi_cnt_q == '1) ? hi_cnt_q : hi_cnt_q + 16'd1;
    lo_inc    = (lo_cnt_q == '1) ? lo_cnt_q : lo_cnt_q + 16'd1;
    word_nx   = {sr_q[22:0], (hi_cnt_q >= THRESH_C)};
    bit_ok    = (state_q == HIGH) && !line_q && (hi_cnt_q >= HMIN_C);
    word_done = bit_ok && (nbits_q == 5'd23);
    too_long  = (state_q == HIGH) && line_q && (hi_inc > HMAX_C);
    // armed_q is set only by a rising edge in LOW, so the gap ending SYNC never latches
    gap_hit   = (state_q == LOW) && !line_q && armed_q && (lo_inc >= RESET_C);
  end

  always_ff @(posedge clk20) begin
    if (reset) begin
      state_q   <= SYNC;
      sync1_q   <= 1'b0;
      line_q    <= 1'b0;
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
      sr_q      <= '0;
      nbits_q   <= '0;
      armed_q   <= 1'b0;
      data_out  <= '0;
      valid     <= 1'b0;
      latch     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1_q   <= din;
      line_q    <= sync1_q;
      latch     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      case (state_q)
        SYNC: begin
          if (line_q) begin
            lo_cnt_q <= '0;
          end else begin
            lo_cnt_q <= lo_inc;
            if (lo_inc >= RESET_C) begin
              state_q <= LOW;
              armed_q <= 1'b0;
            end
          end
        end
        LOW: begin
          if (line_q) begin
            state_q  <= HIGH;
            hi_cnt_q <= 16'd1;
            lo_cnt_q <= '0;
            armed_q  <= 1'b1;
          end else begin
            lo_cnt_q <= lo_inc;
            if (gap_hit) begin
              latch   <= 1'b1;
              armed_q <= 1'b0;
              if (nbits_q != '0) begin
                frame_err <= 1'b1;
                nbits_q   <= '0;
                sr_q      <= '0;
              end
            end
          end
        end
        HIGH: begin
          if (too_long) begin
            frame_err <= 1'b1;
            state_q   <= SYNC;
            hi_cnt_q  <= '0;
            lo_cnt_q  <= '0;
            nbits_q   <= '0;
            sr_q      <= '0;
          end else if (line_q) begin
            hi_cnt_q <= hi_inc;
          end else begin
            state_q  <= LOW;
            hi_cnt_q <= '0;
            lo_cnt_q <= 16'd1;
            if (word_done) begin
              nbits_q <= '0;
              sr_q    <= '0;
              // a word arriving in the accept cycle replaces the consumed one
              if (!valid || ready) begin
                data_out <= word_nx;
                valid    <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else if (bit_ok) begin
              sr_q    <= word_nx;
              nbits_q <= nbits_q + 5'd1;
            end
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

`ifdef WS2812B_RX_FORWARD_EN
  logic fwd_q;

  always_ff @(posedge clk20) begin
    if (reset) begin
      fwd_q <= 1'b0;
    end else if (gap_hit || too_long) begin
      fwd_q <= 1'b0;
    end else if (word_done) begin
      fwd_q <= 1'b1;
    end
  end

  assign dout = fwd_q & line_q;
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx: run-length line model checked every cycle plus literal expectations.
module tb_ws2812b_rx;
  localparam int unsigned HMIN   = 3;
  localparam int unsigned THRESH = 12;
  localparam int unsigned HMAX   = 30;
  localparam int unsigned RST    = 1000;
`ifdef WS2812B_RX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk20 = 1'b0;
  logic        reset = 1'b1;
  logic        din   = 1'b0;
  logic        ready = 1'b0;
  logic [23:0] data_out;
  logic        valid, latch, overrun, frame_err, dout;

  ws2812b_rx #(
    .CYCLES_HMIN  (HMIN),
    .CYCLES_THRESH(THRESH),
    .CYCLES_HMAX  (HMAX),
    .CYCLES_RESET (RST)
  ) dut (
    .clk20    (clk20),
    .reset    (reset),
    .din      (din),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .latch    (latch),
    .overrun  (overrun),
    .frame_err(frame_err),
    .dout     (dout)
  );

  always #5 clk20 = ~clk20;

  // Model: the line as seen two clocks late, classified by run lengths.
  logic        m_s1 = 1'b0, m_s2 = 1'b0, seen;
  bit          m_framed = 1'b0, m_gap_done = 1'b0, m_fwd = 1'b0, consume, load;
  int          m_hi = 0, m_lo = 0, m_nb = 0;
  logic [23:0] m_word = '0, e_data = '0;
  bit          e_valid = 1'b0, e_latch = 1'b0, e_ovr = 1'b0, e_ferr = 1'b0;
  logic        e_dout = 1'b0;

  always @(posedge clk20) begin
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_framed = 1'b0; m_gap_done = 1'b0; m_fwd = 1'b0;
      m_hi = 0; m_lo = 0; m_nb = 0; m_word = '0; e_data = '0;
      e_valid = 1'b0; e_latch = 1'b0; e_ovr = 1'b0; e_ferr = 1'b0;
    end else begin
      seen = m_s2; m_s2 = m_s1; m_s1 = din;
      e_latch = 1'b0; e_ovr = 1'b0; e_ferr = 1'b0; load = 1'b0;
      consume = e_valid && ready;
      if (seen) begin
        m_lo = 0;
        m_hi++;
        if (m_framed) begin
          m_gap_done = 1'b0;
          if (m_hi == HMAX + 1) begin
            e_ferr = 1'b1; m_framed = 1'b0; m_nb = 0; m_fwd = 1'b0;
          end
        end
      end else begin
        if (m_framed && m_hi >= HMIN) begin
          m_word = {m_word[22:0], m_hi >= THRESH};
          m_nb++;
          if (m_nb == 24) begin
            m_nb = 0; m_fwd = 1'b1;
            if (!e_valid || ready) load = 1'b1;
            else e_ovr = 1'b1;
          end
        end
        m_hi = 0;
        m_lo++;
        if (!m_framed) begin
          if (m_lo >= RST) begin m_framed = 1'b1; m_gap_done = 1'b1; end
        end else if (!m_gap_done && m_lo == RST) begin
          e_latch = 1'b1; m_gap_done = 1'b1; m_fwd = 1'b0;
          if (m_nb != 0) begin e_ferr = 1'b1; m_nb = 0; end
        end
      end
      if (load) begin e_data = m_word; e_valid = 1'b1; end
      else if (consume) e_valid = 1'b0;
    end
    e_dout = FWD & m_fwd & m_s2;
  end

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;

  lit_t        lits[128];
  int          lit_wr = 0, lit_rd = 0;
  int          checks = 0, errors = 0;
  int          n_latch = 0, n_ovr = 0, n_ferr = 0, n_both = 0, n_dout_hi = 0;
  logic [23:0] acc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk20) begin
    #1;
    chk("valid",     32'(valid),     32'(e_valid));
    chk("data_out",  32'(data_out),  32'(e_data));
    chk("latch",     32'(latch),     32'(e_latch));
    chk("overrun",   32'(overrun),   32'(e_ovr));
    chk("frame_err", 32'(frame_err), 32'(e_ferr));
    chk("dout",      32'(dout),      32'(e_dout));
    if (latch === 1'b1) n_latch++;
    if (overrun === 1'b1) n_ovr++;
    if (frame_err === 1'b1) n_ferr++;
    if (latch === 1'b1 && frame_err === 1'b1) n_both++;
    if (dout === 1'b1) n_dout_hi++;
    if (valid === 1'b1 && ready === 1'b1) acc.push_back(data_out);
    while (lit_rd < lit_wr) begin
      chk(lits[lit_rd].name, lits[lit_rd].act, lits[lit_rd].exp);
      lit_rd++;
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    lits[lit_wr] = '{name, act, exp};
    lit_wr++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk20);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    tick(n);
  endtask

  task automatic send_bit(input bit b);
    din = 1'b1;
    tick(b ? 16 : 8);
    din = 1'b0;
    tick(b ? 9 : 17);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [23:0] w);
    send_bits(w, 24);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int b_l, b_f, b_o, b_b, b_d, b_a;
    logic [23:0] gw;
    tick(3);
    reset = 1'b0;
    lit("rst_valid", 32'(valid), 32'd0);
    lit("rst_data",  32'(data_out), 32'd0);
    lit("rst_dout",  32'(dout), 32'd0);

    // Basic word after the initial sync gap
    b_l = n_latch;
    gap(1000);
    send_word(24'hA5F00F);
    tick(5);
    lit("s1_valid", 32'(valid), 32'd1);
    lit("s1_data", 32'(data_out), 32'h00A5F00F);
    lit("s1_no_sync_latch", 32'(n_latch - b_l), 32'd0);
    b_l = n_latch; b_f = n_ferr;
    gap(1100);
    lit("s1_one_latch", 32'(n_latch - b_l), 32'd1);
    lit("s1_no_ferr", 32'(n_ferr - b_f), 32'd0);
    lit("s1_valid_kept", 32'(valid), 32'd1);
    ready = 1'b1; tick(2); ready = 1'b0;

    // Overrun with the sink stalled
    b_o = n_ovr;
    send_word(24'h111111);
    send_word(24'h222222);
    tick(5);
    lit("s2_data_kept", 32'(data_out), 32'h00111111);
    lit("s2_overrun", 32'(n_ovr - b_o), 32'd1);
    gap(1100);
    ready = 1'b1; tick(2);

    // Both words delivered in order with ready held high
    b_a = acc.size();
    send_word(24'h111111);
    send_word(24'h222222);
    gap(30);
    lit("s3_count", 32'(acc.size() - b_a), 32'd2);
    lit("s3_first", 32'(acc[b_a]), 32'h00111111);
    lit("s3_second", 32'(acc[b_a + 1]), 32'h00222222);
    gap(1100);

    // Short glitch ignored; overlong high aborts and needs a full gap to resync
    b_a = acc.size();
    gw = 24'h5A3C96;
    for (int i = 23; i >= 0; i--) begin
      send_bit(gw[i]);
      if (i == 12) begin din = 1'b1; tick(2); din = 1'b0; tick(10); end
    end
    gap(30);
    lit("s4_glitch_word", 32'(acc[b_a]), 32'h005A3C96);
    b_f = n_ferr; b_l = n_latch; b_a = acc.size();
    send_bits(24'h123456, 5);
    din = 1'b1; tick(40);
    gap(20);
    send_word(24'hDEAD00);
    gap(1000);
    send_word(24'h654321);
    gap(30);
    lit("s4_ferr", 32'(n_ferr - b_f), 32'd1);
    lit("s4_no_latch", 32'(n_latch - b_l), 32'd0);
    lit("s4_count", 32'(acc.size() - b_a), 32'd1);
    lit("s4_resync_word", 32'(acc[b_a]), 32'h00654321);
    gap(1100);

    // Partial word at latch
    b_b = n_both; b_l = n_latch; b_f = n_ferr;
    send_bits(24'hFFC000, 10);
    gap(1100);
    lit("s5_both", 32'(n_both - b_b), 32'd1);
    lit("s5_latch", 32'(n_latch - b_l), 32'd1);
    lit("s5_ferr", 32'(n_ferr - b_f), 32'd1);
    lit("s5_valid", 32'(valid), 32'd0);

    // Forwarding: silent in word 1, follows line in word 2, silent after latch
    b_d = n_dout_hi;
    send_word(24'h0F0F0F);
    lit("s6_dout_w1", 32'(n_dout_hi - b_d), 32'd0);
    b_d = n_dout_hi;
    send_word(24'hF0F0F0);
    gap(1100);
    lit("s6_dout_w2", 32'(n_dout_hi - b_d), FWD ? 32'd288 : 32'd0);
    b_d = n_dout_hi;
    send_word(24'h0F0F0F);
    gap(30);
    lit("s6_dout_after_latch", 32'(n_dout_hi - b_d), 32'd0);
    gap(1100);

    // Reset mid-word with a pending word
    ready = 1'b0;
    send_word(24'h777777);
    gap(20);
    lit("s7_pending", 32'(valid), 32'd1);
    send_bits(24'hABCDEF, 12);
    reset = 1'b1;
    @(posedge clk20);
    #1;
    lit("s7_rst_valid", 32'(valid), 32'd0);
    lit("s7_rst_data", 32'(data_out), 32'd0);
    lit("s7_rst_pulses", 32'({latch, overrun, frame_err, dout}), 32'd0);
    @(negedge clk20);
    reset = 1'b0;
    gw = 24'hABCDEF;
    for (int i = 11; i >= 0; i--) send_bit(gw[i]);
    gap(20);
    lit("s7_no_partial_valid", 32'(valid), 32'd0);
    lit("s7_no_partial_data", 32'(data_out), 32'd0);
    ready = 1'b1;
    b_a = acc.size();
    gap(1000);
    send_word(24'h00FF00);
    gap(30);
    lit("s7_recover", 32'(acc[b_a]), 32'h0000FF00);
    gap(50);

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812b_rx.md
WS2812B_RX -- requirements
Module: ws2812b_rx

Interface
REQ-001 SHALL have parameter CYCLES_HMIN, default 3: high pulses shorter than this are glitches.
REQ-002 SHALL have parameter CYCLES_THRESH, default 12: high width >= this decodes '1', else '0'.
REQ-003 SHALL have parameter CYCLES_HMAX, default 30: high width > this is a protocol error.
REQ-004 SHALL have parameter CYCLES_RESET, default 1000 (50 us at 20 MHz): low time that marks the latch gap.
REQ-005 SHALL have port clk20, input, 1: 20 MHz clock, the only clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port din, input, 1: asynchronous WS2812B serial line.
REQ-008 SHALL have port data_out, output, 24: received GRB word, MSB first on the wire.
REQ-009 SHALL have port valid, output, 1: data_out holds an unconsumed word.
REQ-010 SHALL have port ready, input, 1: sink accepts data_out when valid & ready.
REQ-011 SHALL have port latch, output, 1: one-cycle pulse at latch-gap detection.
REQ-012 SHALL have port overrun, output, 1: one-cycle pulse when a completed word is dropped.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse on a protocol error.
REQ-014 SHALL have port dout, output, 1: forwarded line (see Configuration).

Function
REQ-015 SHALL pass din through a 2-flop synchronizer; all decoding uses the synchronized value (2-cycle latency).
REQ-016 SHALL implement states SYNC, LOW, HIGH: SYNC waits for low >= CYCLES_RESET, then goes to LOW without pulsing latch; LOW goes to HIGH on a rising edge; HIGH goes to LOW on a falling edge.
REQ-017 SHALL count high width and low width in 16-bit counters, both saturating at all-ones.
REQ-018 SHALL decode a bit on the falling edge: width < CYCLES_HMIN is ignored, so the bit count is unchanged; width < CYCLES_THRESH shifts in 0; otherwise it shifts in 1.
REQ-019 SHALL, when the high width exceeds CYCLES_HMAX, pulse frame_err, discard the partial word and enter SYNC.
REQ-020 SHALL, after the 24th bit, load data_out and set valid on the cycle after the decoding falling edge, then clear the bit count.
REQ-021 SHALL hold data_out stable while valid=1; valid clears on the cycle after valid & ready unless a new word loads in that same cycle.
REQ-022 SHALL, when a word completes while valid=1 and ready=0, keep the old word, drop the new one and pulse overrun.
REQ-023 SHALL, when a word completes in the same cycle as valid & ready, load the new word and keep valid=1 with no overrun.
REQ-024 SHALL, in LOW, pulse latch once when the low count reaches CYCLES_RESET, and not pulse it again until another rising edge.
REQ-025 SHALL, if the bit count is nonzero at latch, also pulse frame_err and discard the partial bits.
REQ-026 SHALL leave valid and data_out unaffected by latch and frame_err.

Reset
REQ-027 SHALL, on reset, enter SYNC and set data_out=0, valid=0, latch=0, overrun=0, frame_err=0, dout=0, and clear all counters and the shift register.
REQ-028 SHALL, on reset asserted mid-word or mid-handshake, drop the word and any pending valid in the same cycle.

Configuration
REQ-029 SHALL, with macro WS2812B_RX_FORWARD_EN defined, hold dout=0 until the first word of a frame has been captured (including a dropped word), then drive dout from the synchronized din until the next latch or error.
REQ-030 SHALL, with WS2812B_RX_FORWARD_EN defined, re-arm the capture-first-word behaviour after each latch or error, so the block chains like a real LED.
REQ-031 SHALL, without WS2812B_RX_FORWARD_EN, tie dout to 0 and include no forwarding logic.

Verification
REQ-032 SHALL cover: after reset, din low for 1000 cycles, then 24 bits of 0xA5F00F at 25 cycles each (T0H=8, T1H=16) -> valid=1, data_out=0xA5F00F, no latch during the initial SYNC.
REQ-033 SHALL cover: ready held 0 and two words 0x111111 and 0x222222 sent -> data_out stays 0x111111 with one overrun pulse; with ready=1 from the start -> both words delivered in order.
REQ-034 SHALL cover: a 2-cycle high glitch inside a word -> ignored, word decodes correctly; a 40-cycle high -> frame_err pulse, then the next word is decoded only after a 1000-cycle low.
REQ-035 SHALL cover: 10 bits followed by 1000 cycles low -> latch and frame_err pulse in the same cycle, valid stays 0; 24 bits followed by 1000 cycles low -> exactly one latch pulse.
REQ-036 SHALL cover, with WS2812B_RX_FORWARD_EN: two words sent -> dout=0 during word 1 and follows din (2-cycle delay) during word 2; after latch, dout=0 again.
REQ-037 SHALL cover: reset asserted at bit 12 -> all outputs 0 on the next cycle and the partial word never appears on data_out.
